io_port_bridge: RTL

Host-side I/O responder for the SimpleProcessor 16-bit data port. Supplies words to the processor's `data_in` from an inbound FIFO and captures words from the processor's `data_out` into an outbound FIFO. Both FIFOs are exchanged with a host through valid/ready streams. Sits between the processor core and the testbench or host stimulus logic; it replaces free-running `data_in` driving with flow-controlled, lossless transfer.

---
 rtl/io_port_bridge_if.sv | 37 +++
 rtl/io_port_bridge.sv | 94 +++++++++
 2 files changed

// File: rtl/io_port_bridge_if.sv
// Processor/host handshake bundle for io_port_bridge.
// The slave modport is the bridge side, and the master modport is the processor/host side.
interface io_port_bridge_if #(
  parameter int unsigned DATA_W = 16
);
  logic [DATA_W-1:0] cpu_data_in;
  logic              cpu_in_avail;
  logic              cpu_rd;
  logic [DATA_W-1:0] cpu_data_out;
  logic              cpu_wr;
  logic              cpu_out_full;
  logic [DATA_W-1:0] host_tx_data;
  logic              host_tx_valid;
  logic              host_tx_ready;
  logic [DATA_W-1:0] host_rx_data;
  logic              host_rx_valid;
  logic              host_rx_ready;
  logic              ovf;
  logic              unf;
  logic              clr_err;

  modport slave (
    output cpu_data_in, cpu_in_avail, cpu_out_full,
    output host_tx_ready, host_rx_data, host_rx_valid,
    output ovf, unf,
    input  cpu_rd, cpu_data_out, cpu_wr,
    input  host_tx_data, host_tx_valid, host_rx_ready, clr_err
  );

  modport master (
    input  cpu_data_in, cpu_in_avail, cpu_out_full,
    input  host_tx_ready, host_rx_data, host_rx_valid,
    input  ovf, unf,
    output cpu_rd, cpu_data_out, cpu_wr,
    output host_tx_data, host_tx_valid, host_rx_ready, clr_err
  );
endinterface

// File: rtl/io_port_bridge.sv
// Flow-controlled bridge between the SimpleProcessor data port and a host.
// It uses an inbound FIFO (host to cpu) and an outbound FIFO (cpu to host), and keeps sticky overflow and underflow flags.
module io_port_bridge #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 4
) (
  input logic            clk,
  input logic            rst,
  io_port_bridge_if.slave bus
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DATA_W-1:0] mem_in  [DEPTH];
  logic [DATA_W-1:0] mem_out [DEPTH];

  logic [AW-1:0] in_rd_ptr, in_wr_ptr, out_rd_ptr, out_wr_ptr;
  logic [CW-1:0] in_count, out_count;
  logic          ovf_q, unf_q;

  logic in_empty, in_full, out_empty, out_full;
  logic in_push, in_pop, out_push, out_pop;

  // Flow control looks only at registered counts, so no input reaches an output combinationally.
  always_comb begin
    in_empty  = (in_count == '0);
    in_full   = (in_count == FULL_CNT);
    out_empty = (out_count == '0);
    out_full  = (out_count == FULL_CNT);
    in_push   = bus.host_tx_valid & ~in_full;
    in_pop    = bus.cpu_rd & ~in_empty;
    out_push  = bus.cpu_wr & ~out_full;
    out_pop   = bus.host_rx_ready & ~out_empty;
  end

  assign bus.cpu_data_in   = in_empty  ? '0 : mem_in[in_rd_ptr];
  assign bus.cpu_in_avail  = ~in_empty;
  assign bus.host_tx_ready = ~in_full;
  assign bus.host_rx_data  = out_empty ? '0 : mem_out[out_rd_ptr];
  assign bus.host_rx_valid = ~out_empty;
  assign bus.cpu_out_full  = out_full;
  assign bus.ovf           = ovf_q;
  assign bus.unf           = unf_q;

  // Storage is left unreset; the empty check masks stale contents.
  always_ff @(posedge clk) begin
    if (in_push)  mem_in[in_wr_ptr]   <= bus.host_tx_data;
    if (out_push) mem_out[out_wr_ptr] <= bus.cpu_data_out;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_rd_ptr <= '0;
      in_wr_ptr <= '0;
      in_count  <= '0;
    end else begin
      if (in_push) in_wr_ptr <= in_wr_ptr + AW'(1);
      if (in_pop)  in_rd_ptr <= in_rd_ptr + AW'(1);
      case ({in_push, in_pop})
        2'b10:   in_count <= in_count + CW'(1);
        2'b01:   in_count <= in_count - CW'(1);
        default: in_count <= in_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_rd_ptr <= '0;
      out_wr_ptr <= '0;
      out_count  <= '0;
    end else begin
      if (out_push) out_wr_ptr <= out_wr_ptr + AW'(1);
      if (out_pop)  out_rd_ptr <= out_rd_ptr + AW'(1);
      case ({out_push, out_pop})
        2'b10:   out_count <= out_count + CW'(1);
        2'b01:   out_count <= out_count - CW'(1);
        default: out_count <= out_count;
      endcase
    end
  end

  // A set event in the same cycle as clr_err wins over the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= (bus.cpu_wr & out_full) | (ovf_q & ~bus.clr_err);
      unf_q <= (bus.cpu_rd & in_empty) | (unf_q & ~bus.clr_err);
    end
  end
endmodule
